// File: rtl/arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_MEM   = 1'b1;
  localparam int   NUM_PORTS  = 2;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/toggle_req_latch.sv
// Per-port toggle-trigger capture: turns a trigger level change into a held request.
module toggle_req_latch #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trig_i,
  input  logic [AW-1:0] addr_i,
  input  logic          rw_i,
  input  logic [DW-1:0] data_i,
  input  logic          clr_i,
  output logic          pending_o,
  output logic [AW-1:0] addr_o,
  output logic          rw_o,
  output logic [DW-1:0] data_o,
  output logic          err_o
);
  logic          seen_q, pend_q, rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          toggle, busy;

  // A request completing on this edge frees the slot for a same-edge toggle.
  assign toggle = trig_i ^ seen_q;
  assign busy   = pend_q & ~clr_i;
  assign err_o  = toggle & busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= trig_i;
      pend_q <= 1'b0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      data_q <= '0;
    end else begin
      seen_q <= trig_i;
      if (toggle && !busy) begin
        pend_q <= 1'b1;
        addr_q <= addr_i;
        rw_q   <= rw_i;
        data_q <= data_i;
      end else if (clr_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pending_o = pend_q;
  assign addr_o    = addr_q;
  assign rw_o      = rw_q;
  assign data_o    = data_q;
endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM between fetch (port 0) and memory stage (port 1); port 1 has
// priority, bounded by a starvation counter protecting port 0.
module ram_arbiter
  import arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          triggerIn0,
  input  logic          triggerIn1,
  input  logic [AW-1:0] addrIn0,
  input  logic [AW-1:0] addrIn1,
  input  logic          rwIn0,
  input  logic          rwIn1,
  input  logic [DW-1:0] dataIn0,
  input  logic [DW-1:0] dataIn1,
  output logic          readyOut0,
  output logic          readyOut1,
  output logic [DW-1:0] dataOut0,
  output logic [DW-1:0] dataOut1,
  output logic          ramReq,
  output logic          ramRw,
  output logic [AW-1:0] ramAddr,
  output logic [DW-1:0] ramDataOut,
  input  logic          ramAck,
  input  logic [DW-1:0] ramDataIn,
  output logic          protocolErr
);
  localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  logic [NUM_PORTS-1:0]         trig, rw_in, rw_l, pend, err, clr;
  logic [NUM_PORTS-1:0][AW-1:0] addr_in, addr_l;
  logic [NUM_PORTS-1:0][DW-1:0] data_in, data_l;

  assign trig    = {triggerIn1, triggerIn0};
  assign rw_in   = {rwIn1, rwIn0};
  assign addr_in = {addrIn1, addrIn0};
  assign data_in = {dataIn1, dataIn0};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    toggle_req_latch #(.AW(AW), .DW(DW)) u_latch (
      .clk      (clk),
      .reset    (reset),
      .trig_i   (trig[p]),
      .addr_i   (addr_in[p]),
      .rw_i     (rw_in[p]),
      .data_i   (data_in[p]),
      .clr_i    (clr[p]),
      .pending_o(pend[p]),
      .addr_o   (addr_l[p]),
      .rw_o     (rw_l[p]),
      .data_o   (data_l[p]),
      .err_o    (err[p])
    );
  end

  arb_state_e                   state_q;
  logic                         grant_q, ramReq_q, ramRw_q, protocolErr_q;
  logic [AW-1:0]                ramAddr_q;
  logic [DW-1:0]                ramDataOut_q;
  logic [NUM_PORTS-1:0][DW-1:0] dataOut_q;
  logic [SCW-1:0]               starveCnt_q, starveCnt_d;
  logic                         issue, done, gnt_sel;

  always_comb begin
    issue   = (state_q == IDLE) && (pend != '0);
    done    = (state_q == REQ) && ramAck;
    gnt_sel = (pend[PORT_MEM] && !(pend[PORT_FETCH] && starveCnt_q == STARVE_MAX))
              ? PORT_MEM : PORT_FETCH;
    clr = '0;
    if (done) clr[grant_q] = 1'b1;
    // Counts port-1 wins only while fetch is actually waiting.
    starveCnt_d = starveCnt_q;
    if (!pend[PORT_FETCH] || (issue && gnt_sel == PORT_FETCH))
      starveCnt_d = '0;
    else if (issue && starveCnt_q != STARVE_MAX)
      starveCnt_d = starveCnt_q + SCW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= PORT_FETCH;
      ramReq_q      <= 1'b0;
      ramRw_q       <= 1'b0;
      ramAddr_q     <= '0;
      ramDataOut_q  <= '0;
      dataOut_q     <= '0;
      starveCnt_q   <= '0;
      protocolErr_q <= 1'b0;
    end else begin
      starveCnt_q <= starveCnt_d;
      if (err != '0) protocolErr_q <= 1'b1;
      case (state_q)
        IDLE: if (issue) begin
          grant_q      <= gnt_sel;
          ramReq_q     <= 1'b1;
          ramRw_q      <= rw_l[gnt_sel];
          ramAddr_q    <= addr_l[gnt_sel];
          ramDataOut_q <= data_l[gnt_sel];
          state_q      <= REQ;
        end
        REQ: if (ramAck) begin
          ramReq_q <= 1'b0;
          if (!ramRw_q) dataOut_q[grant_q] <= ramDataIn;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readyOut0   = ~pend[PORT_FETCH];
  assign readyOut1   = ~pend[PORT_MEM];
  assign dataOut0    = dataOut_q[PORT_FETCH];
  assign dataOut1    = dataOut_q[PORT_MEM];
  assign ramReq      = ramReq_q;
  assign ramRw       = ramRw_q;
  assign ramAddr     = ramAddr_q;
  assign ramDataOut  = ramDataOut_q;
  assign protocolErr = protocolErr_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 32, DW = 32, LIMIT = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic          trig[2], rw[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] wdata[2];
  logic          readyOut0, readyOut1, ramReq, ramRw, ramAck, protocolErr;
  logic [DW-1:0] dataOut0, dataOut1, ramDataOut, ramDataIn;
  logic [AW-1:0] ramAddr;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .triggerIn0(trig[0]), .triggerIn1(trig[1]),
    .addrIn0(addr[0]), .addrIn1(addr[1]),
    .rwIn0(rw[0]), .rwIn1(rw[1]),
    .dataIn0(wdata[0]), .dataIn1(wdata[1]),
    .readyOut0(readyOut0), .readyOut1(readyOut1),
    .dataOut0(dataOut0), .dataOut1(dataOut1),
    .ramReq(ramReq), .ramRw(ramRw), .ramAddr(ramAddr), .ramDataOut(ramDataOut),
    .ramAck(ramAck), .ramDataIn(ramDataIn), .protocolErr(protocolErr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // RAM responder: acks a fixed or random number of cycles after ramReq is seen.
  bit            resp_en = 1'b1, resp_rand = 1'b0;
  int            resp_delay = 1, resp_cnt = 0;
  logic          resp_ack = 1'b0, man_ack = 1'b0;
  logic [DW-1:0] resp_data = '0, man_data = '0, ack_data = '0;
  assign ramAck    = resp_en ? resp_ack  : man_ack;
  assign ramDataIn = resp_en ? resp_data : man_data;

  always @(posedge clk) begin
    #2;
    resp_ack = 1'b0;
    if (ramReq) begin
      if (resp_cnt == 0 && resp_rand) resp_delay = $urandom_range(3, 1);
      resp_cnt++;
      if (resp_cnt == resp_delay) begin
        resp_ack  = 1'b1;
        resp_data = resp_rand ? $urandom : ack_data;
      end
    end else begin
      resp_cnt = 0;
      if (resp_rand && $urandom_range(7, 0) == 0) begin
        resp_ack  = 1'b1;
        resp_data = $urandom;
      end
    end
  end

  // Reference model: one outstanding request slot per port, one RAM transaction
  // at a time, m_wait = port-1 wins since port 0 began waiting.
  bit            m_live = 1'b0, m_busy, m_g, m_rw, m_err;
  bit            m_seen[2], m_pend[2], m_lrw[2];
  logic [AW-1:0] m_la[2], m_addr;
  logic [DW-1:0] m_ld[2], m_wd, m_dout[2];
  int            m_wait;

  always @(posedge clk) begin
    bit was_pend[2];
    bit was_busy, fin, g;
    m_live = 1'b1;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_seen[p] = trig[p]; m_pend[p] = 0; m_dout[p] = '0;
        m_la[p] = '0; m_lrw[p] = 0; m_ld[p] = '0;
      end
      m_busy = 0; m_g = 0; m_rw = 0; m_addr = '0; m_wd = '0; m_err = 0; m_wait = 0;
    end else begin
      was_pend = m_pend;
      was_busy = m_busy;
      fin = was_busy && ramAck;
      if (fin) begin
        if (!m_rw) m_dout[m_g] = ramDataIn;
        m_pend[m_g] = 0;
        m_busy = 0;
      end
      if (!was_busy && (was_pend[0] || was_pend[1])) begin
        g = (was_pend[0] && was_pend[1]) ? (m_wait < LIMIT) : was_pend[1];
        if (!g) m_wait = 0;
        else if (was_pend[0]) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
        m_busy = 1; m_g = g;
        m_rw = m_lrw[g]; m_addr = m_la[g]; m_wd = m_ld[g];
      end
      if (!was_pend[0]) m_wait = 0;
      for (int p = 0; p < 2; p++) begin
        if (trig[p] != m_seen[p]) begin
          m_seen[p] = trig[p];
          if (was_pend[p] && !(fin && int'(m_g) == p)) m_err = 1;
          else begin
            m_pend[p] = 1; m_la[p] = addr[p]; m_lrw[p] = rw[p]; m_ld[p] = wdata[p];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("readyOut0",   32'(readyOut0),   32'(!m_pend[0]));
      chk("readyOut1",   32'(readyOut1),   32'(!m_pend[1]));
      chk("dataOut0",    dataOut0,         m_dout[0]);
      chk("dataOut1",    dataOut1,         m_dout[1]);
      chk("ramReq",      32'(ramReq),      32'(m_busy));
      chk("ramRw",       32'(ramRw),       32'(m_rw));
      chk("ramAddr",     ramAddr,          m_addr);
      chk("ramDataOut",  ramDataOut,       m_wd);
      chk("protocolErr", 32'(protocolErr), 32'(m_err));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, rises;
    logic prev;
    logic [5:0] seq;
    bit q[$];
    for (int p = 0; p < 2; p++) begin
      trig[p] = 1'b0; rw[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
    trig[0] = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    chk("t1_ready0", 32'(readyOut0), 32'd1);
    chk("t1_ready1", 32'(readyOut1), 32'd1);
    chk("t1_ramReq", 32'(ramReq), 32'd0);

    // Port 1 load, ack sampled two cycles after ramReq rises
    resp_delay = 2; ack_data = 32'hDEADBEEF;
    addr[1] = 32'h40; rw[1] = 1'b0; trig[1] = ~trig[1];
    cyc; chk("t2_ready_low", 32'(readyOut1), 32'd0);
    cyc; chk("t2_ramReq", 32'(ramReq), 32'd1); chk("t2_addr", ramAddr, 32'h40);
    cyc; chk("t2_ready_still_low", 32'(readyOut1), 32'd0);
    cyc; chk("t2_ready_high", 32'(readyOut1), 32'd1);
    chk("t2_data", dataOut1, 32'hDEADBEEF);

    // Simultaneous fetch load and memory store
    cyc(2);
    resp_delay = 1; ack_data = 32'h12345678;
    addr[0] = 32'h10; rw[0] = 1'b0;
    addr[1] = 32'h20; rw[1] = 1'b1; wdata[1] = 32'h55;
    trig[0] = ~trig[0]; trig[1] = ~trig[1];
    cyc(2);
    chk("t3_p1_req", 32'(ramReq), 32'd1); chk("t3_p1_addr", ramAddr, 32'h20);
    chk("t3_p1_rw", 32'(ramRw), 32'd1);   chk("t3_p1_wd", ramDataOut, 32'h55);
    cyc; chk("t3_gap", 32'(ramReq), 32'd0);
    cyc; chk("t3_p0_req", 32'(ramReq), 32'd1); chk("t3_p0_addr", ramAddr, 32'h10);
    chk("t3_p0_rw", 32'(ramRw), 32'd0);
    cyc; chk("t3_ready0", 32'(readyOut0), 32'd1);
    chk("t3_data0", dataOut0, 32'h12345678);
    chk("t3_data1_kept", dataOut1, 32'hDEADBEEF);

    // Starvation guard: port 1 re-requests on each of its completion edges
    cyc(2);
    addr[0] = 32'h100; rw[0] = 1'b0; addr[1] = 32'h200; rw[1] = 1'b0;
    trig[0] = ~trig[0]; trig[1] = ~trig[1];
    n1 = 1; prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc;
      if (ramReq && !prev) q.push_back(ramAddr == 32'h200);
      if (ramReq && ramAddr == 32'h200 && n1 < 6) begin trig[1] = ~trig[1]; n1++; end
      prev = ramReq;
    end
    chk("t4_grant_count", 32'(q.size()), 32'd7);
    seq = '0;
    for (int i = 0; i < 6 && i < q.size(); i++) seq[5-i] = q[i];
    chk("t4_grant_order", 32'(seq), 32'b111101);
    chk("t4_no_err", 32'(protocolErr), 32'd0);

    // Two extra toggles while port 1 is outstanding
    cyc(2);
    resp_delay = 4; addr[1] = 32'h300; rw[1] = 1'b0;
    trig[1] = ~trig[1];
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc;
      if (ramReq && !prev) rises++;
      prev = ramReq;
      if (i < 2) trig[1] = ~trig[1];
    end
    chk("t5_one_txn", 32'(rises), 32'd1);
    chk("t5_err", 32'(protocolErr), 32'd1);
    chk("t5_ready1", 32'(readyOut1), 32'd1);

    // Reset in the middle of a RAM transaction, then a stray ack
    cyc(2);
    resp_delay = 100; addr[0] = 32'h500; rw[0] = 1'b0;
    trig[0] = ~trig[0];
    cyc(2); chk("t6_req_up", 32'(ramReq), 32'd1);
    reset = 1'b1;
    cyc;
    chk("t6_req_drop", 32'(ramReq), 32'd0);
    chk("t6_ready0", 32'(readyOut0), 32'd1);
    chk("t6_ready1", 32'(readyOut1), 32'd1);
    chk("t6_err_clr", 32'(protocolErr), 32'd0);
    reset = 1'b0; resp_en = 1'b0; man_data = 32'hBAD; man_ack = 1'b1;
    cyc; man_ack = 1'b0;
    cyc;
    chk("t6_late_ack_req", 32'(ramReq), 32'd0);
    chk("t6_late_ack_data", dataOut0, 32'd0);
    chk("t6_late_ack_ready", 32'(readyOut0), 32'd1);
    resp_en = 1'b1;

    // Randomized traffic against the model
    resp_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      cyc;
      reset = ($urandom_range(299, 0) == 0);
      for (int p = 0; p < 2; p++) begin
        addr[p]  = $urandom;
        wdata[p] = $urandom;
        rw[p]    = 1'($urandom_range(1, 0));
        if (((p == 0) ? readyOut0 : readyOut1) ? ($urandom_range(3, 0) == 0)
                                               : ($urandom_range(39, 0) == 0))
          trig[p] = ~trig[p];
      end
    end
    reset = 1'b0;
    cyc(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Clocked two-port arbiter that shares the single data/instruction RAM between the fetch stage (port 0) and the memory stage (port 1). Each requester keeps the codebase's toggle-trigger/level-ready handshake. The arbiter latches each request, grants the RAM under fixed priority with a starvation guard, and runs a level req/ack transaction on the RAM side. It sits between the pipeline stages and the RAM model and replaces their direct RAM wiring.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive port-1 grants while port 0 is pending.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `triggerIn0` / `triggerIn1` in 1: request toggle; any change of level is one new request.
- `addrIn0` / `addrIn1` in AW: request address.
- `rwIn0` / `rwIn1` in 1: 0 = load, 1 = store.
- `dataIn0` / `dataIn1` in DW: store data.
- `readyOut0` / `readyOut1` out 1: high when the port has no outstanding request.
- `dataOut0` / `dataOut1` out DW: load result; holds its value until the next load completes on that port.
- `ramReq` out 1: RAM request.
- `ramRw` out 1: RAM read/write select.
- `ramAddr` out AW: RAM address.
- `ramDataOut` out DW: RAM write data.
- `ramAck` in 1: one-cycle completion strobe from the RAM.
- `ramDataIn` in DW: RAM read data; valid when `ramAck` is high.
- `protocolErr` out 1: sticky; set when a toggle arrives on a port whose request is still outstanding.

## Operation
- Per port, a `trigSeen` register holds the last sampled trigger level. `triggerInN != trigSeenN` while the port is not pending is a new request. On that edge:
  - set `pendingN`;
  - latch addr, rw and data;
  - clear `readyOutN`;
  - update `trigSeenN`.
- A toggle while `pendingN` is set: `trigSeenN` updates, the request is dropped, `protocolErr` is set. The outstanding request is unaffected.
- FSM states `IDLE`, `REQ`:
  - `IDLE`: if any port is pending, choose the grant port, drive `ramReq`=1 with the latched fields, go to `REQ`.
  - `REQ`: hold all RAM outputs stable until `ramAck` is sampled high. On that edge:
    - `ramReq`=0;
    - if the request was a load, `dataOutN` ← `ramDataIn`;
    - clear `pendingN`, set `readyOutN`=1;
    - go to `IDLE`.
- Grant rule: port 1 wins when both ports are pending, except when `starveCnt` == `STARVE_LIMIT`; then port 0 wins.
- `starveCnt` (width $clog2(STARVE_LIMIT+1)):
  - increments on a port-1 grant made while port 0 is pending;
  - clears on any port-0 grant or whenever port 0 is not pending;
  - saturates at `STARVE_LIMIT`.
- A store completes only on `ramAck`. `ramDataIn` is ignored for stores.
- `ramAck` sampled high outside `REQ` is ignored.

## Timing
- Reset values:
  - `readyOut0/1`=1, `dataOut0/1`=0;
  - `ramReq`=0, `ramRw`=0, `ramAddr`=0, `ramDataOut`=0;
  - `protocolErr`=0, `starveCnt`=0, pending=0, state `IDLE`.
- During reset, `trigSeenN` ← `triggerInN`, so no request is seen at release.
- Reset in `REQ`: the transaction is abandoned; `ramReq` drops on the reset edge and no data is written back.
- Latency, with the toggle sampled at edge E1:
  - E1: `readyOutN` falls;
  - E2: `ramReq` rises (if `IDLE`);
  - earliest `ramAck` sample is E3, which raises `readyOutN`.
  - Minimum toggle-to-ready is 3 edges.
- Back-to-back: a request already pending for the other port issues at the edge after completion. `ramReq` is low for exactly one cycle between transactions.
- Same-port re-request: a toggle is accepted at or after the edge where `readyOutN` rises. A toggle sampled on that same completion edge is a new request, not an error.
- A new request on one port while the other port is in `REQ` is latched and waits.

## Structure
- `arbiter_pkg`:
  - state enum (`IDLE`, `REQ`);
  - port index constants `PORT_FETCH`=0, `PORT_MEM`=1;
  - default widths.
- Sub-module `toggle_req_latch`, instantiated per port. It holds:
  - `trigSeen`, pending, the latched addr/rw/data;
  - the error pulse output;
  - a clear input driven by the FSM.
- Top level holds the FSM, grant logic, `starveCnt`, and the output registers.

## Test plan
- Reset with `triggerIn0`=1: after release, no request is issued, `readyOut0`=1, `ramReq`=0.
- Port 1 load, addr 0x40, RAM acks 2 cycles after `ramReq` rises with data 0xDEADBEEF -> `dataOut1`=0xDEADBEEF and `readyOut1` rises 4 edges after the toggle edge.
- Both ports toggle on the same edge (0x10 fetch, 0x20 store of 0x55) -> port 1 is served first, then port 0 after one idle cycle. `dataOut1` is unchanged by the store.
- Port 0 stays pending while port 1 re-requests continuously -> exactly 4 port-1 grants, then a port-0 grant, then port 1 again.
- Port 1 toggles twice while pending -> one RAM transaction only, and `protocolErr`=1 until reset.
- `reset` asserted mid-`REQ` -> `ramReq`=0 on that edge, `readyOut0/1`=1, and a late `ramAck` after release is ignored.
